// File: rtl/mod_exp_pkg.sv
// Shared types and constants for the modular exponentiation sequencer.
package mod_exp_pkg;

    localparam int WIDTH = 64;
    localparam logic [WIDTH-1:0] MM_ONE = 64'd1;

    // Main sequencer states: domain entry, square/multiply loop, domain exit.
    typedef enum logic [2:0] {
        IDLE,
        XBAR,
        ACC1,
        SQR,
        MUL,
        EXIT,
        DONE
    } main_state_t;

    // Handshake phases of a single Montgomery multiplication.
    typedef enum logic [1:0] {
        GAP,
        RUN,
        CAPTURE
    } op_state_t;

endpackage

// File: rtl/mod_exp_ctrl_mm_op_seq.sv
// One Montgomery multiplication: GO/is_ready handshake with the shared
// multiplier plus the final conditional subtraction of the modulus.
// GAP doubles as the resting phase, so mm_go is low whenever no op runs.
module mm_op_seq
    import mod_exp_pkg::*;
(
    input  logic             pclk,
    input  logic             nreset,
    input  logic             op_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_m,
    input  logic [WIDTH+1:0] mm_p,
    input  logic             mm_ready,
    output logic             mm_go,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    output logic             op_done,
    output logic [WIDTH-1:0] op_result
);

    op_state_t op_state_reg;
    op_state_t op_state_next;

    logic [WIDTH+1:0] wide_m;

    assign mm_a   = op_a;
    assign mm_b   = op_b;
    assign mm_m   = op_m;
    assign wide_m = {2'b00, op_m};

    // Handshake phase register.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            op_state_reg <= GAP;
        end else begin
            op_state_reg <= op_state_next;
        end
    end

    // Phase sequencing; GAP is always exactly one cycle when a request is pending.
    always_comb begin
        op_state_next = op_state_reg;
        mm_go         = 1'b0;
        op_done       = 1'b0;
        case (op_state_reg)
            GAP: begin
                if (op_start) begin
                    op_state_next = RUN;
                end
            end
            RUN: begin
                mm_go = 1'b1;
                if (mm_ready) begin
                    op_state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                mm_go         = 1'b1;
                op_done       = 1'b1;
                op_state_next = GAP;
            end
            default: begin
                op_state_next = GAP;
            end
        endcase
    end

    // Product is below 2M, so a single subtraction fully reduces it.
    always_comb begin
        if (mm_p >= wide_m) begin
            op_result = WIDTH'(mm_p - wide_m);
        end else begin
            op_result = mm_p[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation in the Montgomery domain,
// driving one shared Montgomery multiplier through mm_op_seq.
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int EXP_W = 64
) (
    input  logic             pclk,
    input  logic             nreset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             mm_go,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH+1:0] mm_p,
    input  logic             mm_ready
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

    main_state_t      state_reg;
    main_state_t      state_next;

    logic [WIDTH-1:0] base_reg;
    logic [EXP_W-1:0] exp_reg;
    logic [WIDTH-1:0] mod_reg;
    logic [WIDTH-1:0] r2_reg;
    logic [WIDTH-1:0] xbar_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             err_reg;
    logic [WIDTH-1:0] result_reg;

    logic             op_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_done;
    logic [WIDTH-1:0] op_result;

    assign busy   = (state_reg != IDLE) && (state_reg != DONE);
    assign done   = (state_reg == DONE);
    assign err    = err_reg;
    assign result = result_reg;

    mm_op_seq u_op_seq (
        .pclk      (pclk),
        .nreset    (nreset),
        .op_start  (op_start),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_m      (mod_reg),
        .mm_p      (mm_p),
        .mm_ready  (mm_ready),
        .mm_go     (mm_go),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .op_done   (op_done),
        .op_result (op_result)
    );

    // Main state register.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and operand selection; every op state keeps requesting
    // multiplications until its result is captured.
    always_comb begin
        state_next = state_reg;
        op_start   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = modulus[0] ? XBAR : DONE;
                end
            end
            XBAR: begin
                op_start = 1'b1;
                op_a     = base_reg;
                op_b     = r2_reg;
                if (op_done) state_next = ACC1;
            end
            ACC1: begin
                op_start = 1'b1;
                op_a     = MM_ONE;
                op_b     = r2_reg;
                if (op_done) state_next = SQR;
            end
            SQR: begin
                op_start = 1'b1;
                op_a     = acc_reg;
                op_b     = acc_reg;
                if (op_done) begin
                    if (exp_reg[idx_reg])  state_next = MUL;
                    else if (idx_reg == 0) state_next = EXIT;
                    else                   state_next = SQR;
                end
            end
            MUL: begin
                op_start = 1'b1;
                op_a     = acc_reg;
                op_b     = xbar_reg;
                if (op_done) state_next = (idx_reg == 0) ? EXIT : SQR;
            end
            EXIT: begin
                op_start = 1'b1;
                op_a     = acc_reg;
                op_b     = MM_ONE;
                if (op_done) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latches, accumulator, bit index and result/error registers.
    always_ff @(posedge pclk) begin
        if (!nreset) begin
            base_reg   <= '0;
            exp_reg    <= '0;
            mod_reg    <= '0;
            r2_reg     <= '0;
            xbar_reg   <= '0;
            acc_reg    <= '0;
            idx_reg    <= '0;
            err_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg   <= base;
                        exp_reg    <= exponent;
                        mod_reg    <= modulus;
                        r2_reg     <= r2;
                        idx_reg    <= IDX_TOP;
                        err_reg    <= ~modulus[0];
                        result_reg <= '0;
                    end
                end
                XBAR: begin
                    if (op_done) xbar_reg <= op_result;
                end
                ACC1: begin
                    if (op_done) acc_reg <= op_result;
                end
                SQR: begin
                    if (op_done) begin
                        acc_reg <= op_result;
                        if (!exp_reg[idx_reg] && (idx_reg != 0)) idx_reg <= idx_reg - 1'b1;
                    end
                end
                MUL: begin
                    if (op_done) begin
                        acc_reg <= op_result;
                        if (idx_reg != 0) idx_reg <= idx_reg - 1'b1;
                    end
                end
                EXIT: begin
                    if (op_done) result_reg <= op_result;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural Montgomery multiplier.
module tb_mod_exp_ctrl;
    import mod_exp_pkg::*;

    localparam int EXP_W = 64;

    logic        pclk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] base = '0;
    logic [63:0] exponent = '0;
    logic [63:0] modulus = '0;
    logic [63:0] r2 = '0;
    logic        busy, done, err, mm_go;
    logic [63:0] result, mm_a, mm_b, mm_m;
    logic [65:0] mm_p = '0;
    logic        mm_ready = 1'b0;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          ops;
    } exp_t;
    exp_t sb_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int mm_cnt = 0;
    int mm_lat = 1;
    bit mm_force = 1'b0;
    int op_count = 0;
    int go_cycles = 0;
    int gap_err = 0;
    int low_len = 0;
    bit had_op = 1'b0;
    int ops_base = 0;
    int go_base = 0;

    always #5 pclk = ~pclk;

    mod_exp_ctrl #(.EXP_W(EXP_W)) dut (
        .pclk(pclk), .nreset(nreset), .start(start), .base(base),
        .exponent(exponent), .modulus(modulus), .r2(r2), .busy(busy),
        .done(done), .err(err), .result(result), .mm_go(mm_go),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_p(mm_p), .mm_ready(mm_ready)
    );

    // Montgomery product a*b*2^-64 mod m via REDC, left unreduced (< 2m).
    // With frc set, values below m are lifted by m to exercise the subtraction.
    function automatic logic [65:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m, input bit frc);
        logic [127:0] ab;
        logic [63:0]  minv, q, ab_lo;
        logic [191:0] s;
        logic [65:0]  t;
        minv = m;
        for (int k = 0; k < 6; k++) minv = minv * (64'd2 - m * minv);
        ab    = 128'(a) * 128'(b);
        ab_lo = ab[63:0];
        q     = 64'd0 - ab_lo * minv;
        s     = 192'(ab) + 192'(q) * 192'(m);
        t     = s[129:64];
        if (frc && (t < {2'b00, m})) t = t + {2'b00, m};
        return t;
    endfunction

    function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] m);
        logic [127:0] r, bb, mm;
        mm = 128'(m);
        bb = 128'(b);
        r  = 128'd1 % mm;
        for (int k = 63; k >= 0; k--) begin
            r = (r * r) % mm;
            if (e[k]) r = (r * bb) % mm;
        end
        return r[63:0];
    endfunction

    function automatic logic [63:0] calc_r2(input logic [63:0] m);
        logic [127:0] rm, sq;
        rm = (128'd1 << 64) % 128'(m);
        sq = (rm * rm) % 128'(m);
        return sq[63:0];
    endfunction

    // Behavioural multiplier: fixed latency after GO, cleared whenever GO is low.
    always @(posedge pclk) begin
        if (!mm_go) begin
            mm_cnt   <= 0;
            mm_ready <= 1'b0;
        end else if (!mm_ready) begin
            if (mm_cnt >= mm_lat) begin
                mm_ready <= 1'b1;
                mm_p     <= mont(mm_a, mm_b, mm_m, mm_force);
                op_count <= op_count + 1;
            end else begin
                mm_cnt <= mm_cnt + 1;
            end
        end
    end

    // Tracks GO-high cycles and the GO-low gap between ops of one run.
    always @(negedge pclk) begin
        if (mm_go) go_cycles <= go_cycles + 1;
        if (!nreset || !busy) begin
            had_op  <= 1'b0;
            low_len <= 0;
        end else if (mm_go) begin
            if (had_op && low_len > 1) gap_err <= gap_err + 1;
            low_len <= 0;
            had_op  <= 1'b1;
        end else begin
            low_len <= low_len + 1;
        end
    end

    task automatic start_op(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                            input logic [63:0] rr, input int lat, input bit frc);
        exp_t x;
        @(posedge pclk); #1;
        mm_lat   = lat;
        mm_force = frc;
        base     = b;
        exponent = e;
        modulus  = m;
        r2       = rr;
        start    = 1'b1;
        ops_base = op_count;
        go_base  = go_cycles;
        x.err = ~m[0];
        x.res = m[0] ? modexp(b, e, m) : 64'd0;
        x.ops = m[0] ? (3 + EXP_W + $countones(e)) : 0;
        sb_q.push_back(x);
        @(posedge pclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 5000) begin
            @(negedge pclk);
            cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge pclk);
        tests_run++;
        if ({busy, done, err, mm_go} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/err/go got %b want 0000", {busy, done, err, mm_go});
        end
        tests_run++;
        if (result !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        tests_run++;
        if ((mm_a | mm_b | mm_m) !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_operands: a %h b %h m %h want 0", mm_a, mm_b, mm_m);
        end
        @(posedge pclk); #1;
        nreset = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] tb_b[2], tb_e[2], tb_m[2], tb_r[2];
        bit seen; int cyc; exp_t x;
        tb_b[0] = 64'd4; tb_e[0] = 64'd13; tb_m[0] = 64'd13; tb_r[0] = 64'd9;
        tb_b[1] = 64'd2; tb_e[1] = 64'hFFFF_FFFF_FFFF_FFC4;
        tb_m[1] = 64'hFFFF_FFFF_FFFF_FFC5; tb_r[1] = 64'hD99;
        for (int i = 0; i < 2; i++) begin
            start_op(tb_b[i], tb_e[i], tb_m[i], tb_r[i], i + 1, 1'b0);
            wait_done(seen, cyc);
            tests_run++;
            if (!seen || sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL basic_timeout[%0d]: done seen %0d want 1", i, seen);
                sb_q.delete();
            end else begin
                x = sb_q.pop_front();
                $display("[TB] txn basic[%0d] result %h err %0b ops %0d", i, result, err, op_count - ops_base);
                if (result !== x.res || err !== x.err) begin
                    tests_failed++;
                    $display("FAIL basic_result[%0d]: got %h/%0b want %h/%0b", i, result, err, x.res, x.err);
                end
                tests_run++;
                if (op_count - ops_base != x.ops) begin
                    tests_failed++;
                    $display("FAIL basic_opcount[%0d]: got %0d want %0d", i, op_count - ops_base, x.ops);
                end
                tests_run++;
                if (go_cycles - go_base != x.ops * (i + 4)) begin
                    tests_failed++;
                    $display("FAIL basic_go_cycles[%0d]: got %0d want %0d", i, go_cycles - go_base, x.ops * (i + 4));
                end
            end
        end
    endtask

    task automatic test_even_modulus();
        bit seen; int cyc; exp_t x;
        start_op(64'd3, 64'd5, 64'h10, 64'd0, 1, 1'b0);
        wait_done(seen, cyc);
        tests_run++;
        if (!seen || cyc > 3 || sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL even_done: seen %0d after %0d cycles want within 3", seen, cyc);
            sb_q.delete();
        end else begin
            x = sb_q.pop_front();
            $display("[TB] txn even result %h err %0b", result, err);
            if (result !== x.res || err !== x.err) begin
                tests_failed++;
                $display("FAIL even_result: got %h/%0b want %h/%0b", result, err, x.res, x.err);
            end
        end
        @(negedge pclk);
        tests_run++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL even_err_hold: err %0b busy %0b want 1/0", err, busy);
        end
        tests_run++;
        if (go_cycles != go_base) begin
            tests_failed++;
            $display("FAIL even_no_go: go cycles %0d want 0", go_cycles - go_base);
        end
    endtask

    task automatic test_exp_zero();
        logic [63:0] tb_b[2], tb_m[2];
        bit seen; int cyc; exp_t x;
        tb_b[0] = 64'd7; tb_m[0] = 64'd13;
        tb_b[1] = 64'd0; tb_m[1] = 64'd1;
        for (int i = 0; i < 2; i++) begin
            start_op(tb_b[i], 64'd0, tb_m[i], calc_r2(tb_m[i]), 0, 1'b1);
            wait_done(seen, cyc);
            tests_run++;
            if (!seen || sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL exp0_timeout[%0d]: done seen %0d want 1", i, seen);
                sb_q.delete();
            end else begin
                x = sb_q.pop_front();
                $display("[TB] txn exp0[%0d] result %h err %0b ops %0d", i, result, err, op_count - ops_base);
                if (result !== x.res || err !== x.err || op_count - ops_base != x.ops) begin
                    tests_failed++;
                    $display("FAIL exp0_result[%0d]: got %h/%0b/%0d want %h/%0b/%0d", i, result, err,
                             op_count - ops_base, x.res, x.err, x.ops);
                end
            end
        end
    endtask

    task automatic test_golden();
        logic [63:0] m, b, e;
        bit seen; int cyc; exp_t x;
        for (int i = 0; i < 3; i++) begin
            m = {$urandom, $urandom} | 64'd1;
            b = {$urandom, $urandom} % m;
            e = {$urandom, $urandom};
            start_op(b, e, m, calc_r2(m), int'($urandom_range(0, 3)), i[0]);
            wait_done(seen, cyc);
            tests_run++;
            if (!seen || sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL golden_timeout[%0d]: done seen %0d want 1", i, seen);
                sb_q.delete();
            end else begin
                x = sb_q.pop_front();
                $display("[TB] txn golden[%0d] m %h result %h ops %0d", i, m, result, op_count - ops_base);
                if (result !== x.res || err !== x.err || op_count - ops_base != x.ops) begin
                    tests_failed++;
                    $display("FAIL golden_result[%0d]: got %h/%0b/%0d want %h/%0b/%0d", i, result, err,
                             op_count - ops_base, x.res, x.err, x.ops);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        bit seen; int cyc; exp_t x;
        start_op(64'd4, 64'd13, 64'd13, 64'd9, 1, 1'b0);
        repeat (15) @(posedge pclk);
        #1;
        base = 64'd5; exponent = 64'd3; modulus = 64'd11; r2 = calc_r2(64'd11);
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_busy: got %0b want 1", busy);
        end
        wait_done(seen, cyc);
        tests_run++;
        if (!seen || sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL ignore_timeout: done seen %0d want 1", seen);
            sb_q.delete();
        end else begin
            x = sb_q.pop_front();
            $display("[TB] txn ignore result %h ops %0d", result, op_count - ops_base);
            if (result !== x.res || op_count - ops_base != x.ops) begin
                tests_failed++;
                $display("FAIL ignore_result: got %h/%0d want %h/%0d", result, op_count - ops_base, x.res, x.ops);
            end
        end
    endtask

    task automatic test_reset_midrun();
        bit seen; int cyc; int c; bit done_seen; exp_t x;
        start_op(64'd4, 64'd13, 64'd13, 64'd9, 1, 1'b0);
        c = 0;
        while (dut.state_reg != SQR && c < 200) begin
            @(negedge pclk);
            c++;
        end
        tests_run++;
        if (dut.state_reg != SQR) begin
            tests_failed++;
            $display("FAIL midrun_reach_sqr: state %0d want SQR", dut.state_reg);
        end
        nreset = 1'b0;
        @(posedge pclk); #1;
        tests_run++;
        if ({busy, mm_go, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL midrun_abort: busy/go/done got %b want 000", {busy, mm_go, done});
        end
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            if (done) done_seen = 1'b1;
        end
        tests_run++;
        if (done_seen) begin
            tests_failed++;
            $display("FAIL midrun_no_done: done seen 1 want 0");
        end
        sb_q.delete();
        @(posedge pclk); #1;
        nreset = 1'b1;
        start_op(64'd3, 64'd5, 64'd13, 64'd9, 2, 1'b1);
        wait_done(seen, cyc);
        tests_run++;
        if (!seen || sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL midrun_restart_timeout: done seen %0d want 1", seen);
            sb_q.delete();
        end else begin
            x = sb_q.pop_front();
            $display("[TB] txn restart result %h ops %0d", result, op_count - ops_base);
            if (result !== x.res || err !== x.err || op_count - ops_base != x.ops) begin
                tests_failed++;
                $display("FAIL midrun_restart_result: got %h/%0d want %h/%0d", result, op_count - ops_base, x.res, x.ops);
            end
        end
    endtask

    task automatic test_gap();
        @(negedge pclk);
        tests_run++;
        if (gap_err != 0) begin
            tests_failed++;
            $display("FAIL go_gap: %0d gaps longer than one cycle, want 0", gap_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_even_modulus();
        test_exp_zero();
        test_golden();
        test_start_ignored();
        test_reset_midrun();
        test_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Sequencer that computes result = base^exponent mod modulus by issuing a chain of Montgomery multiplications to one shared 64-bit Montgomery multiplier instance (GO / is_ready handshake, 66-bit product). It runs left-to-right binary square-and-multiply in the Montgomery domain, handling domain entry, per-op conditional final subtraction and domain exit. It sits between the APB-facing register file (start, operands, status) and the multiplier.

Parameters:
EXP_W, 64, exponent width in bits; also the loop count.
WIDTH, 64, operand width; fixed to the multiplier width and not to be overridden.

Ports:
pclk  in  1  clock
nreset  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
base  in  64  base, must be < modulus
exponent  in  EXP_W  exponent
modulus  in  64  modulus M, must be odd
r2  in  64  R^2 mod M, R = 2^64, precomputed by software
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
err  out  1  high with done if M is even; held until next start
result  out  64  final value; held until next accepted start
mm_go  out  1  multiplier GO; low clears the multiplier
mm_a  out  64  multiplier operand A
mm_b  out  64  multiplier operand B
mm_m  out  64  multiplier modulus
mm_p  in  66  multiplier product
mm_ready  in  1  multiplier is_ready

Behaviour:
- Reset: nreset synchronous, active-low; clock pclk. Reset values: busy=0, done=0, err=0, result=0, mm_go=0, mm_a=0, mm_b=0, mm_m=0; state IDLE; internal registers 0. A reset mid-operation aborts immediately with no done pulse, and mm_go=0 on the next edge.
- IDLE: start=1 latches base, exponent, modulus and r2; sets busy=1; clears err and result.
- Start while busy is ignored. Later changes to the inputs do not affect a running operation.
- If modulus[0]=0, go to DONE with err=1 and result=0; no multiplier op is issued.
- Op engine, per multiplication:
  - GAP: mm_go=0 for exactly 1 cycle with mm_a, mm_b and mm_m driven.
  - RUN: mm_go=1, operands stable, wait for mm_ready=1.
  - CAPTURE: v = mm_p. If v >= {2'b0,M}, store (v - M)[63:0]; otherwise store v[63:0]. mm_go stays 1 in this cycle and drops in the next GAP or IDLE.
- mm_m = latched modulus throughout an operation.
- Main FSM: IDLE -> XBAR -> ACC1 -> SQR <-> MUL -> EXIT -> DONE -> IDLE.
  - XBAR: xbar = MM(base, r2).
  - ACC1: acc = MM(1, r2).
  - SQR: acc = MM(acc, acc). Then go to MUL if exponent[i]=1; otherwise decrement i and go to SQR, or to EXIT when i=0.
  - MUL: acc = MM(acc, xbar). Then decrement i and go to SQR, or to EXIT when i=0.
  - i starts at EXP_W-1. Leading zero bits are not skipped (fixed square count).
  - EXIT: result = MM(acc, 1).
  - DONE: done=1 for 1 cycle, busy=0 in the same cycle, then IDLE.
- Op count = 3 + EXP_W + popcount(exponent). Per-op latency = 1 (GAP) + multiplier latency + 1 (CAPTURE).
- exponent=0: all SQR, no MUL; result = 1 mod M (0 if M=1).
- The bit index counter is log2(EXP_W) bits wide and counts down without wrapping. Termination is detected at 0 and does not rely on underflow.
- mm_ready is ignored outside RUN.

Decomposition:
- Package mod_exp_pkg holds: main-state enum (IDLE, XBAR, ACC1, SQR, MUL, EXIT, DONE), op-engine enum (GAP, RUN, CAPTURE), WIDTH=64, MM_ONE=64'd1.
- Sub-module mm_op_seq holds the GAP/RUN/CAPTURE handshake plus conditional subtraction. It has an op_start/op_done interface to the main FSM.
- Top-level FSM, latches and index counter stay in mod_exp_ctrl.

Test Plan:
- M=13, r2=9, base=4, exp=13 -> done pulse, result=4, err=0, op count 3+64+3=70.
- M=0xFFFFFFFFFFFFFFC5, r2=0xD99, base=2, exp=M-1 -> result=1.
- M=13, r2=9, base=7, exp=0 -> result=1. Additionally, a product exactly >= M at CAPTURE is reduced, checked against a golden model.
- modulus=0x10 (even), start -> err=1 and done within 3 cycles, result=0, mm_go never asserted.
- Second start pulse mid-run with different operands -> ignored; first result (4, from the first scenario) returned.
- nreset low during SQR -> next edge: busy=0, mm_go=0, no done. A fresh start after reset completes correctly. Check that mm_go is low exactly 1 cycle between consecutive ops.
